bnn_layer_sequencer: RTL and testbench

- Sequences one fully-connected binary layer of the MNIST BNN: walks every output neuron over every input chunk and issues read strobes/addresses to the pixel and weight registers.
- Accumulates the per-chunk XNOR-popcount returned by the datapath, thresholds the sum into one activation bit per neuron, writes it out, then pulses done.
- One instance serves each layer state of the top FSM. `start` is driven on layer-state entry. `done` drives the matching layer_N_done input.

---
 rtl/bnn_layer_sequencer_if.sv | 44 ++++
 rtl/bnn_layer_sequencer.sv | 140 ++++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bnn_layer_sequencer_if.sv
// ============================================================================
// Module   : bnn_layer_sequencer_if
// Brief    : Control/datapath bundle between a BNN layer sequencer and its
//            pixel/weight registers, popcount datapath and activation store.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bnn_layer_sequencer_if #(
  parameter int N_IN    = 784,
  parameter int CHUNK_W = 16,
  parameter int N_OUT   = 32
);
  localparam int NCHUNK = N_IN / CHUNK_W;
  localparam int ACC_W  = $clog2(N_IN + 1);
  localparam int PC_W   = $clog2(CHUNK_W + 1);
  localparam int CA_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int WA_W   = (N_OUT * NCHUNK > 1) ? $clog2(N_OUT * NCHUNK) : 1;
  localparam int NO_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic             start;
  logic [ACC_W-1:0] thresh;
  logic             rd_en;
  logic [CA_W-1:0]  chunk_addr;
  logic [WA_W-1:0]  w_addr;
  logic [PC_W-1:0]  pop_cnt;
  logic             out_we;
  logic [NO_W-1:0]  out_addr;
  logic             out_bit;
  logic             busy;
  logic             done;

  modport master (
    input  start, thresh, pop_cnt,
    output rd_en, chunk_addr, w_addr, out_we, out_addr, out_bit, busy, done
  );

  modport slave (
    output start, thresh, pop_cnt,
    input  rd_en, chunk_addr, w_addr, out_we, out_addr, out_bit, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/bnn_layer_sequencer.sv
// ============================================================================
// Module   : bnn_layer_sequencer
// Brief    : Walks every output neuron over every input chunk of one binary
//            FC layer, accumulates XNOR-popcounts and writes threshold bits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bnn_layer_sequencer #(
  parameter int N_IN    = 784,
  parameter int CHUNK_W = 16,
  parameter int N_OUT   = 32
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  bnn_layer_sequencer_if.master   bus
);
  localparam int NCHUNK = N_IN / CHUNK_W;
  localparam int ACC_W  = $clog2(N_IN + 1);
  localparam int PC_W   = $clog2(CHUNK_W + 1);
  localparam int CA_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int WA_W   = (N_OUT * NCHUNK > 1) ? $clog2(N_OUT * NCHUNK) : 1;
  localparam int NO_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CA_W-1:0] CHUNK_LAST  = CA_W'(NCHUNK - 1);
  localparam logic [NO_W-1:0] NEURON_LAST = NO_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_ACC_LAST = 3'd2,
    S_WRITE    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NO_W-1:0]  r_neuron;
  logic [NO_W-1:0]  w_neuron_nxt;
  logic [CA_W-1:0]  r_chunk;
  logic [CA_W-1:0]  w_chunk_nxt;
  logic [ACC_W-1:0] r_acc;
  logic             r_pv;
  logic             r_first_d;

  logic             w_rd_en;
  logic             w_out_we;
  logic             w_busy;
  logic             w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_neuron_nxt = r_neuron;
    w_chunk_nxt  = r_chunk;
    w_rd_en      = 1'b0;
    w_out_we     = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt  = S_RUN;
          w_neuron_nxt = '0;
          w_chunk_nxt  = '0;
        end
      end
      S_RUN: begin
        w_rd_en = 1'b1;
        w_busy  = 1'b1;
        if (r_chunk == CHUNK_LAST) begin
          w_chunk_nxt = '0;
          w_state_nxt = S_ACC_LAST;
        end else begin
          w_chunk_nxt = r_chunk + CA_W'(1);
        end
      end
      S_ACC_LAST: begin
        w_busy      = 1'b1;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_busy   = 1'b1;
        w_out_we = 1'b1;
        if (r_neuron == NEURON_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_neuron_nxt = r_neuron + NO_W'(1);
          w_state_nxt  = S_RUN;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pop counts arrive one cycle after the read; the first chunk of a neuron
  // overwrites acc so no separate clear cycle is spent between neurons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neuron  <= '0;
      r_chunk   <= '0;
      r_acc     <= '0;
      r_pv      <= 1'b0;
      r_first_d <= 1'b0;
    end else begin
      r_neuron  <= w_neuron_nxt;
      r_chunk   <= w_chunk_nxt;
      r_pv      <= w_rd_en;
      r_first_d <= w_rd_en && (r_chunk == '0);
      if (r_pv) begin
        r_acc <= r_first_d ? ACC_W'(bus.pop_cnt) : r_acc + ACC_W'(bus.pop_cnt);
      end
    end
  end

  assign bus.rd_en      = w_rd_en;
  assign bus.chunk_addr = w_rd_en ? r_chunk : '0;
  assign bus.w_addr     = w_rd_en ? (WA_W'(r_neuron) * WA_W'(NCHUNK) + WA_W'(r_chunk)) : '0;
  assign bus.out_we     = w_out_we;
  assign bus.out_addr   = w_out_we ? r_neuron : '0;
  assign bus.out_bit    = w_out_we && (r_acc >= bus.thresh);
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

endmodule

`default_nettype wire

// File: tb/tb_bnn_layer_sequencer.sv
// ============================================================================
// Module   : tb_bnn_layer_sequencer
// Brief    : Directed bench: a small 32/16/2 layer and the default 784/16/32.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bnn_layer_sequencer;
  logic clk;
  logic rst_n_s;
  logic rst_n_d;
  int   total;
  int   bad;

  bnn_layer_sequencer_if #(.N_IN(32),  .CHUNK_W(16), .N_OUT(2))  sif ();
  bnn_layer_sequencer_if #(.N_IN(784), .CHUNK_W(16), .N_OUT(32)) dif ();

  bnn_layer_sequencer #(.N_IN(32), .CHUNK_W(16), .N_OUT(2)) u_small (
    .clk   (clk),
    .rst_n (rst_n_s),
    .bus   (sif.master)
  );

  bnn_layer_sequencer #(.N_IN(784), .CHUNK_W(16), .N_OUT(32)) u_dflt (
    .clk   (clk),
    .rst_n (rst_n_d),
    .bus   (dif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath models: fixed 1-cycle read latency, garbage when no read was issued.
  logic [4:0]  pop_s [4];
  logic        rd_q_s;
  logic [1:0]  addr_q_s;
  logic        rd_q_d;
  logic [10:0] addr_q_d;

  always @(posedge clk) begin
    rd_q_s   <= sif.rd_en;
    addr_q_s <= sif.w_addr;
    rd_q_d   <= dif.rd_en;
    addr_q_d <= dif.w_addr;
  end

  assign sif.pop_cnt = rd_q_s ? pop_s[addr_q_s] : 5'h1F;
  assign dif.pop_cnt = rd_q_d ? 5'(32'(addr_q_d) % 17) : 5'h1F;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] small_outs();
    return 32'({sif.rd_en, sif.out_we, sif.out_bit, sif.busy, sif.done,
                sif.chunk_addr, sif.w_addr, sif.out_addr});
  endfunction

  function automatic logic [31:0] dflt_outs();
    return 32'({dif.rd_en, dif.out_we, dif.out_bit, dif.busy, dif.done,
                dif.chunk_addr, dif.w_addr, dif.out_addr});
  endfunction

  function automatic int exp_acc_d(input int n);
    int s = 0;
    for (int c = 0; c < 49; c++) s += (n * 49 + c) % 17;
    return s;
  endfunction

  // Full small-layer cycle walk; start is high in cycle 0, samples cycles 1..10.
  task automatic walk_small(input string tag);
    logic [9:0] rd_exp, we_exp, busy_exp, done_exp, bit_exp;
    rd_exp   = 10'b0000110011;
    we_exp   = 10'b0010001000;
    busy_exp = 10'b0011111111;
    done_exp = 10'b0100000000;
    bit_exp  = 10'b0000001000;
    pop_s[0] = 5'd10; pop_s[1] = 5'd10; pop_s[2] = 5'd10; pop_s[3] = 5'd9;
    sif.thresh = 6'd20;
    sif.start  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      sif.start = 1'b0;
      check({tag, "_rd_en"},   32'(sif.rd_en),   32'(rd_exp[k-1]));
      check({tag, "_out_we"},  32'(sif.out_we),  32'(we_exp[k-1]));
      check({tag, "_busy"},    32'(sif.busy),    32'(busy_exp[k-1]));
      check({tag, "_done"},    32'(sif.done),    32'(done_exp[k-1]));
      check({tag, "_out_bit"}, 32'(sif.out_bit), 32'(bit_exp[k-1]));
      if (rd_exp[k-1]) begin
        check({tag, "_w_addr"},     32'(sif.w_addr),     (k <= 2) ? 32'(k - 1) : 32'(k - 3));
        check({tag, "_chunk_addr"}, 32'(sif.chunk_addr), 32'((k - 1) % 2));
      end
      if (we_exp[k-1]) begin
        check({tag, "_out_addr"}, 32'(sif.out_addr), (k == 4) ? 32'd0 : 32'd1);
      end
    end
  endtask

  task automatic small_bits(input logic [4:0] p, input logic [5:0] th,
                            output logic [1:0] bits, output int nwe);
    bits = 2'bxx;
    nwe  = 0;
    for (int i = 0; i < 4; i++) pop_s[i] = p;
    sif.thresh = th;
    sif.start  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      sif.start = 1'b0;
      if (sif.out_we) begin
        bits[sif.out_addr] = sif.out_bit;
        nwe++;
      end
    end
  endtask

  initial begin
    logic [1:0] bits;
    int nwe, we_cnt, done_cnt, done_cyc, rd_cnt;
    total = 0;
    bad   = 0;
    rst_n_s = 1'b0;
    rst_n_d = 1'b0;
    sif.start = 1'b0; sif.thresh = '0;
    dif.start = 1'b0; dif.thresh = '0;
    for (int i = 0; i < 4; i++) pop_s[i] = '0;

    // Reset and idle with start low
    repeat (3) @(negedge clk);
    check("rst_small_outs", small_outs(), 32'd0);
    check("rst_dflt_outs",  dflt_outs(),  32'd0);
    rst_n_s = 1'b1;
    rst_n_d = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_small_outs", small_outs(), 32'd0);
      check("idle_dflt_outs",  dflt_outs(),  32'd0);
    end

    // Address walk and threshold compare with acc reload between neurons
    walk_small("walk");

    // Extremes
    small_bits(5'd16, 6'd32, bits, nwe);
    check("ext_full_t32_nwe",  32'(nwe),  32'd2);
    check("ext_full_t32_bits", 32'(bits), 32'b11);
    small_bits(5'd16, 6'd33, bits, nwe);
    check("ext_full_t33_nwe",  32'(nwe),  32'd2);
    check("ext_full_t33_bits", 32'(bits), 32'b00);
    small_bits(5'd0, 6'd0, bits, nwe);
    check("ext_zero_t0_nwe",  32'(nwe),  32'd2);
    check("ext_zero_t0_bits", 32'(bits), 32'b11);

    // Reset mid-layer in cycle 6, then a fresh layer from scratch
    pop_s[0] = 5'd10; pop_s[1] = 5'd10; pop_s[2] = 5'd10; pop_s[3] = 5'd9;
    sif.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      sif.start = 1'b0;
    end
    check("abort_pre_rd_en", 32'(sif.rd_en), 32'd1);
    rst_n_s = 1'b0;
    #1;
    check("abort_outs_drop", small_outs(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n_s = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("abort_quiet", 32'({sif.out_we, sif.done, sif.busy, sif.rd_en}), 32'd0);
    end
    walk_small("rerun");

    // Default layer with start held, re-pulsed mid-run and during DONE
    dif.thresh = 10'd392;
    dif.start  = 1'b1;
    we_cnt = 0; done_cnt = 0; done_cyc = 0; rd_cnt = 0;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      if (dif.rd_en) rd_cnt++;
      if (dif.out_we) begin
        check("dflt_out_addr", 32'(dif.out_addr), 32'(we_cnt));
        check("dflt_out_bit",  32'(dif.out_bit),  32'(exp_acc_d(we_cnt) >= 392));
        we_cnt++;
      end
      if (dif.done) begin
        done_cnt++;
        done_cyc = k;
      end
      dif.start = (k <= 2) || (k == 500) || (k == 1633);
    end
    check("dflt_we_count",   32'(we_cnt),   32'd32);
    check("dflt_done_count", 32'(done_cnt), 32'd1);
    check("dflt_done_cycle", 32'(done_cyc), 32'd1633);
    check("dflt_rd_count",   32'(rd_cnt),   32'd1568);
    check("dflt_end_idle",   dflt_outs(),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
